// File: rtl/lsu_subword_ctrl.sv
// rtl/lsu_subword_ctrl.sv - RV32I byte/half/word load-store unit in front of a word-only data memory
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return an error instead of being aligned down.
module lsu_subword_ctrl #(
    parameter int DM_DEPTH = 256,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              busy_o,
    output logic              dm_mem_read_o,
    output logic              dm_mem_write_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [31:0]       dm_wdata_o,
    input  logic [31:0]       dm_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              f3_bad;
    logic              range_bad;
    logic              misalign_bad;
    logic              req_err;

    always_comb begin
        if (req_we_i) begin
            f3_bad = !(req_funct3_i == 3'b000 || req_funct3_i == 3'b001 || req_funct3_i == 3'b010);
        end else begin
            f3_bad = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
        end
    end

    assign range_bad = (req_addr_i >> 2) >= ADDR_W'(DM_DEPTH);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_bad = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
                        || ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
    assign misalign_bad = 1'b0;
`endif

    assign req_err = f3_bad || range_bad || misalign_bad;

    // Lane extraction and merge only look at the latched address, so a misaligned
    // half collapses onto addr[1] and a misaligned word ignores the low bits.
    logic [4:0]  byte_sh, half_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign byte_sh = {addr_q[1:0], 3'b000};
    assign half_sh = {addr_q[1], 4'b0000};
    assign ld_byte = 8'(dm_rdata_i >> byte_sh);
    assign ld_half = addr_q[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];

    always_comb begin
        case (funct3_q)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_val = {24'h000000, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_val = {16'h0000, ld_half};
            default: load_val = dm_rdata_i;
        endcase
    end

    always_comb begin
        if (funct3_q[1:0] == 2'b01) begin
            merged = (dm_rdata_i & ~(32'h0000FFFF << half_sh))
                   | ({16'h0000, wdata_q[15:0]} << half_sh);
        end else begin
            merged = (dm_rdata_i & ~(32'h000000FF << byte_sh))
                   | ({24'h000000, wdata_q[7:0]} << byte_sh);
        end
    end

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        funct3_d       = funct3_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        merge_d        = merge_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        req_ready_o    = 1'b0;
        resp_valid_o   = 1'b0;
        dm_mem_read_o  = 1'b0;
        dm_mem_write_o = 1'b0;
        dm_wdata_o     = 32'h0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    rdata_d  = 32'h0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!req_we_i) begin
                        state_d = S_LOAD;
                    end else if (req_funct3_i == 3'b010) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                dm_mem_read_o = 1'b1;
                rdata_d       = load_val;
                state_d       = S_RESP;
            end
            S_RMW_RD: begin
                dm_mem_read_o = 1'b1;
                merge_d       = merged;
                state_d       = S_WRITE;
            end
            S_WRITE: begin
                dm_mem_write_o = 1'b1;
                dm_wdata_o     = (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;
                state_d        = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign resp_rdata_o = we_q ? 32'h0 : rdata_q;
    assign resp_err_o   = err_q;
    assign dm_addr_o    = {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// tb/tb_lsu_subword_ctrl.sv - directed self-checking bench for lsu_subword_ctrl with a behavioural word memory
module tb_lsu_subword_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_subword_ctrl #(.DM_DEPTH(256), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_funct3_i   (req_funct3),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .busy_o         (busy),
        .dm_mem_read_o  (dm_mem_read),
        .dm_mem_write_o (dm_mem_write),
        .dm_addr_o      (dm_addr),
        .dm_wdata_o     (dm_wdata),
        .dm_rdata_i     (dm_rdata)
    );

    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (dm_mem_write && dm_addr[31:10] == 22'h0) begin
            mem[dm_addr[9:2]] <= dm_wdata;
        end
    end

    assign dm_rdata = (dm_addr[31:10] == 22'h0) ? mem[dm_addr[9:2]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access: present, accept, then watch strobes until resp_valid (bounded).
    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int exp_lat, input int exp_rd, input int exp_wr,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int lat, nrd, nwr;
        logic [31:0] waddr, rdata;
        logic err, done;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; nrd = 0; nwr = 0; waddr = 32'h0; rdata = 32'hX; err = 1'bX; done = 1'b0;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            if (dm_mem_read) nrd++;
            if (dm_mem_write) begin
                nwr++;
                waddr = dm_addr;
            end
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
                done  = 1'b1;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rd"}, 32'(nrd), 32'(exp_rd));
        chk({tag, "_wr"}, 32'(nwr), 32'(exp_wr));
        if (exp_wr != 0) chk({tag, "_waddr"}, waddr, {a[31:2], 2'b00});
        chk({tag, "_rdata"}, rdata, exp_rdata);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        int nwr, nresp;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", {30'h0, dm_mem_read, dm_mem_write}, 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);

        run("sw_10",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 0, 1, 32'h0, 1'b0);
        run("lw_10",   1'b0, 3'b010, 32'h10, 32'h0,        2, 1, 0, 32'hDEADBEEF, 1'b0);
        run("sb_12",   1'b1, 3'b000, 32'h12, 32'h00000055, 3, 1, 1, 32'h0, 1'b0);
        run("lw_10b",  1'b0, 3'b010, 32'h10, 32'h0,        2, 1, 0, 32'hDE55BEEF, 1'b0);
        run("lb_13",   1'b0, 3'b000, 32'h13, 32'h0,        2, 1, 0, 32'hFFFFFFDE, 1'b0);
        run("lbu_13",  1'b0, 3'b100, 32'h13, 32'h0,        2, 1, 0, 32'h000000DE, 1'b0);
        run("lh_10",   1'b0, 3'b001, 32'h10, 32'h0,        2, 1, 0, 32'hFFFFBEEF, 1'b0);
        run("lhu_12",  1'b0, 3'b101, 32'h12, 32'h0,        2, 1, 0, 32'h0000DE55, 1'b0);

        run("lw_oor",  1'b0, 3'b010, 32'h400, 32'h0,       1, 0, 0, 32'h0, 1'b1);
        run("st_f4",   1'b1, 3'b100, 32'h10, 32'h11111111, 1, 0, 0, 32'h0, 1'b1);
        run("ld_f3",   1'b0, 3'b011, 32'h10, 32'h0,        1, 0, 0, 32'h0, 1'b1);
        run("ld_f6",   1'b0, 3'b110, 32'h10, 32'h0,        1, 0, 0, 32'h0, 1'b1);

        run("sw_top",  1'b1, 3'b010, 32'h3FC, 32'h12345678, 2, 0, 1, 32'h0, 1'b0);
        run("sh_top",  1'b1, 3'b001, 32'h3FE, 32'h0000A5A5, 3, 1, 1, 32'h0, 1'b0);
        run("lw_top",  1'b0, 3'b010, 32'h3FC, 32'h0,        2, 1, 0, 32'hA5A55678, 1'b0);
        run("lb_top",  1'b0, 3'b000, 32'h3FC, 32'h0,        2, 1, 0, 32'h00000078, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
        run("lh_11",   1'b0, 3'b001, 32'h11, 32'h0,        1, 0, 0, 32'h0, 1'b1);
        run("lw_12",   1'b0, 3'b010, 32'h12, 32'h0,        1, 0, 0, 32'h0, 1'b1);
`else
        run("lh_11",   1'b0, 3'b001, 32'h11, 32'h0,        2, 1, 0, 32'hFFFFBEEF, 1'b0);
        run("lw_12",   1'b0, 3'b010, 32'h12, 32'h0,        2, 1, 0, 32'hDE55BEEF, 1'b0);
`endif

        // Reset while an SB sits in its read phase of the read-modify-write.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h00000077;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_rmw_rd", {30'h0, busy, dm_mem_read}, 32'h3);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        nwr = 0;
        nresp = 0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            if (dm_mem_write) nwr++;
            if (resp_valid) nresp++;
            @(negedge clk);
        end
        chk("rst_mid_wr", 32'(nwr), 32'd0);
        chk("rst_mid_resp", 32'(nresp), 32'd0);
        run("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1, 0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
